// File: rtl/banked_word_memory.sv
// banked_word_memory
//   Dual-port word memory built from DATA_WIDTH/8 byte-lane banks, shared by
//   the core's instruction and data interfaces. Both ports share one clock.
//   Each port takes valid/ready requests with per-byte write strobes.
//   Reads are answered READ_LATENCY cycles after acceptance with a one-cycle
//   data_valid pulse. Each port's read data holds between responses.
//   With CLEAR_ON_RESET=1, every word is zeroed after reset before any
//   request is accepted.
//
// Ports
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   init_done_o             clear sequence finished, memory usable
//   {A,B}_valid_i/_ready_o  request handshake (ready has no backpressure)
//   {A,B}_address_i         word address; addresses >= MEMORY_SIZE are
//                           ignored on write and read back as 0
//   {A,B}_write_i           1 = write, 0 = read
//   {A,B}_strobe_i          byte-lane write enables
//   {A,B}_data_i/_data_o    write data / read response data
//   {A,B}_data_valid_o      read response pulse
//   collision_o             (only with BANKED_MEMORY_COLLISION_EN) pulses the
//                           cycle after both ports hit the same in-range word
//                           with at least one of them writing
//
// Optional feature macro: BANKED_MEMORY_COLLISION_EN
//
// States
//   state | meaning
//   CLEAR | zeroing word clr_cnt_q, requests ignored
//   READY | accepting requests on both ports

module banked_word_memory #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEMORY_SIZE    = 1024,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int AW    = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
`ifdef BANKED_MEMORY_COLLISION_EN
  output logic                  collision_o,
`endif
  output logic                  init_done_o,

  input  logic                  A_valid_i,
  output logic                  A_ready_o,
  input  logic [AW-1:0]         A_address_i,
  input  logic                  A_write_i,
  input  logic [LANES-1:0]      A_strobe_i,
  input  logic [DATA_WIDTH-1:0] A_data_i,
  output logic [DATA_WIDTH-1:0] A_data_o,
  output logic                  A_data_valid_o,

  input  logic                  B_valid_i,
  output logic                  B_ready_o,
  input  logic [AW-1:0]         B_address_i,
  input  logic                  B_write_i,
  input  logic [LANES-1:0]      B_strobe_i,
  input  logic [DATA_WIDTH-1:0] B_data_i,
  output logic [DATA_WIDTH-1:0] B_data_o,
  output logic                  B_data_valid_o
);

  localparam logic [AW:0]   MEM_DEPTH = (AW+1)'(MEMORY_SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEMORY_SIZE - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            clear_we;
  logic            ready_q;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_SIZE];

  logic a_acc, b_acc;
  logic a_in_range, b_in_range;
  logic a_wr, b_wr;
  logic [1:0]            rd_acc;
  logic [DATA_WIDTH-1:0] rd_word [2];

  logic [DATA_WIDTH-1:0]   rd_pipe_q [2][READ_LATENCY];
  logic [READ_LATENCY-1:0] rd_vld_q  [2];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      if (CLEAR_ON_RESET != 0) state_q <= CLEAR;
      else                     state_q <= READY;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == READY);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clear_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = READY;
        else                        clr_cnt_d = clr_cnt_q + AW'(1);
      end
      READY:   ;
      default: state_d = READY;
    endcase
  end

  assign A_ready_o   = ready_q;
  assign B_ready_o   = ready_q;
  assign init_done_o = ready_q;

  // ---------------------------------------------------------- requests
  assign a_acc      = A_valid_i && ready_q;
  assign b_acc      = B_valid_i && ready_q;
  assign a_in_range = ({1'b0, A_address_i} < MEM_DEPTH);
  assign b_in_range = ({1'b0, B_address_i} < MEM_DEPTH);
  assign a_wr       = a_acc && A_write_i && a_in_range;
  assign b_wr       = b_acc && B_write_i && b_in_range;
  assign rd_acc     = {b_acc && !B_write_i, a_acc && !A_write_i};

  // Reads sample the array before this edge's writes land (read-first).
  always_comb begin
    rd_word[0] = '0;
    rd_word[1] = '0;
    if (a_in_range) rd_word[0] = mem_q[A_address_i];
    if (b_in_range) rd_word[1] = mem_q[B_address_i];
  end

  // ------------------------------------------------------------ storage
  // Port A lanes are assigned after port B so A wins on shared lanes.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (clear_we) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        for (int l = 0; l < LANES; l++) begin
          if (b_wr && B_strobe_i[l]) mem_q[B_address_i][8*l +: 8] <= B_data_i[8*l +: 8];
          if (a_wr && A_strobe_i[l]) mem_q[A_address_i][8*l +: 8] <= A_data_i[8*l +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------ read pipeline
  // Stage data only moves with a valid, so the last stage holds the most
  // recent response between pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int p = 0; p < 2; p++) begin
        rd_vld_q[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) rd_pipe_q[p][s] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        rd_vld_q[p][0] <= rd_acc[p];
        if (rd_acc[p]) rd_pipe_q[p][0] <= rd_word[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          rd_vld_q[p][s] <= rd_vld_q[p][s-1];
          if (rd_vld_q[p][s-1]) rd_pipe_q[p][s] <= rd_pipe_q[p][s-1];
        end
      end
    end
  end

  assign A_data_o       = rd_pipe_q[0][READ_LATENCY-1];
  assign A_data_valid_o = rd_vld_q[0][READ_LATENCY-1];
  assign B_data_o       = rd_pipe_q[1][READ_LATENCY-1];
  assign B_data_valid_o = rd_vld_q[1][READ_LATENCY-1];

`ifdef BANKED_MEMORY_COLLISION_EN
  logic collision_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= a_acc && b_acc && (A_address_i == B_address_i) &&
                     a_in_range && (A_write_i || B_write_i);
    end
  end

  assign collision_o = collision_q;
`endif

endmodule

// File: tb/tb_banked_word_memory.sv
module tb_banked_word_memory;

  localparam int DW = 32;
  localparam int MS = 12;
  localparam int RL = 3;
  localparam int LN = DW / 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          init_done;
  logic          a_valid, a_ready, a_write, a_dv;
  logic [AW-1:0] a_addr;
  logic [LN-1:0] a_strobe;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_ready, b_write, b_dv;
  logic [AW-1:0] b_addr;
  logic [LN-1:0] b_strobe;
  logic [DW-1:0] b_wdata, b_rdata;
`ifdef BANKED_MEMORY_COLLISION_EN
  logic          collision;
`endif

  banked_word_memory #(
    .DATA_WIDTH(DW), .MEMORY_SIZE(MS), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
`ifdef BANKED_MEMORY_COLLISION_EN
    .collision_o(collision),
`endif
    .init_done_o(init_done),
    .A_valid_i(a_valid), .A_ready_o(a_ready), .A_address_i(a_addr),
    .A_write_i(a_write), .A_strobe_i(a_strobe), .A_data_i(a_wdata),
    .A_data_o(a_rdata), .A_data_valid_o(a_dv),
    .B_valid_i(b_valid), .B_ready_o(b_ready), .B_address_i(b_addr),
    .B_write_i(b_write), .B_strobe_i(b_strobe), .B_data_i(b_wdata),
    .B_data_o(b_rdata), .B_data_valid_o(b_dv)
  );

  // ---------------------------------------------------- reference model
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            dir;
    logic [DW-1:0] dval;
  } resp_t;

  logic [DW-1:0] m_mem [MS];
  resp_t         qa[$], qb[$];
  logic [DW-1:0] last_a, last_b;
  bit            m_ready, exp_coll;
  int            clr_left, cyc;
  bit            dir_a_en, dir_b_en;
  logic [DW-1:0] dir_a_val, dir_b_val;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw,
                                          logic [LN-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < LN; l++) if (st[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  task automatic tick();
    bit acc_a, acc_b, coll, exp_av, exp_bv;
    resp_t r;
    acc_a = rst_n && m_ready && a_valid;
    acc_b = rst_n && m_ready && b_valid;
    coll  = acc_a && acc_b && (a_addr == b_addr) && (a_addr < MS) && (a_write || b_write);
    if (acc_a && !a_write)
      qa.push_back('{cyc + RL, (a_addr < MS) ? m_mem[a_addr] : '0, dir_a_en, dir_a_val});
    if (acc_b && !b_write)
      qb.push_back('{cyc + RL, (b_addr < MS) ? m_mem[b_addr] : '0, dir_b_en, dir_b_val});
    if (acc_b && b_write && b_addr < MS) m_mem[b_addr] = merge(m_mem[b_addr], b_wdata, b_strobe);
    if (acc_a && a_write && a_addr < MS) m_mem[a_addr] = merge(m_mem[a_addr], a_wdata, a_strobe);
    dir_a_en = 1'b0;
    dir_b_en = 1'b0;

    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      m_ready  = 1'b0;
      clr_left = MS;
      exp_coll = 1'b0;
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      exp_coll = coll;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          foreach (m_mem[i]) m_mem[i] = '0;
          m_ready = 1'b1;
        end
      end
    end

    exp_av = (qa.size() > 0) && (qa[0].due == cyc);
    exp_bv = (qb.size() > 0) && (qb[0].due == cyc);
    if (exp_av) begin
      r = qa.pop_front();
      last_a = r.data;
      if (r.dir) chk("a_directed_data", a_rdata, r.dval);
    end
    if (exp_bv) begin
      r = qb.pop_front();
      last_b = r.data;
      if (r.dir) chk("b_directed_data", b_rdata, r.dval);
    end
    chk("a_data_valid", a_dv, exp_av);
    chk("b_data_valid", b_dv, exp_bv);
    chk("a_data", a_rdata, last_a);
    chk("b_data", b_rdata, last_b);
    chk("a_ready", a_ready, m_ready);
    chk("b_ready", b_ready, m_ready);
    chk("init_done", init_done, m_ready);
`ifdef BANKED_MEMORY_COLLISION_EN
    chk("collision", collision, exp_coll);
`endif
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drive_a(int op, int addr, int strb, logic [DW-1:0] data);
    a_valid   = (op != 0);
    a_write   = (op == 2);
    a_addr    = AW'(addr);
    a_strobe  = LN'(strb);
    a_wdata   = (op == 2) ? data : $urandom();
    dir_a_en  = (op == 1);
    dir_a_val = data;
  endtask

  task automatic drive_b(int op, int addr, int strb, logic [DW-1:0] data);
    b_valid   = (op != 0);
    b_write   = (op == 2);
    b_addr    = AW'(addr);
    b_strobe  = LN'(strb);
    b_wdata   = (op == 2) ? data : $urandom();
    dir_b_en  = (op == 1);
    dir_b_val = data;
  endtask

  task automatic drive_random();
    a_valid  = ($urandom_range(0, 9) < 7);
    a_write  = $urandom_range(0, 1) == 1;
    a_addr   = AW'($urandom_range(0, 15));
    a_strobe = LN'($urandom());
    a_wdata  = $urandom();
    b_valid  = ($urandom_range(0, 9) < 7);
    b_write  = $urandom_range(0, 1) == 1;
    b_addr   = ($urandom_range(0, 3) == 0) ? a_addr : AW'($urandom_range(0, 15));
    b_strobe = LN'($urandom());
    b_wdata  = $urandom();
  endtask

  // Counts cycles until ready rises; bounded so a stuck clear still ends.
  task automatic count_clear(string nm);
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < MS + 8) begin
      drive_random();
      tick();
      n++;
    end
    idle();
    chk(nm, n, MS);
  endtask

  // op: 0 idle, 1 read (data = expected response), 2 write (data = write data)
  typedef struct {
    int aop, aaddr, astrb; logic [DW-1:0] adata;
    int bop, baddr, bstrb; logic [DW-1:0] bdata;
  } vec_t;

  function automatic vec_t mk(int aop, int aaddr, int astrb, logic [DW-1:0] adata,
                              int bop, int baddr, int bstrb, logic [DW-1:0] bdata);
    vec_t v;
    v.aop = aop; v.aaddr = aaddr; v.astrb = astrb; v.adata = adata;
    v.bop = bop; v.baddr = baddr; v.bstrb = bstrb; v.bdata = bdata;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(2, 5, 'hf, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    tbl[1]  = mk(2, 5, 'h5, 32'h11223344, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 5, 0, 32'hDE22BE44, 2, 3, 'hf, 32'h5555AAAA);
    tbl[3]  = mk(2, 2, 'hf, 32'hCAFEF00D, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 2, 0, 32'hCAFEF00D, 0, 0, 0, 32'h0);
    tbl[5]  = mk(1, 3, 0, 32'h5555AAAA, 0, 0, 0, 32'h0);
    tbl[6]  = mk(2, 7, 'hc, 32'hAAAAAAAA, 2, 7, 'h6, 32'hBBBBBBBB);
    tbl[7]  = mk(1, 7, 0, 32'hAAAABB00, 0, 0, 0, 32'h0);
    tbl[8]  = mk(2, 9, 'hf, 32'h12345678, 1, 9, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0, 1, 9, 0, 32'h12345678);
    tbl[10] = mk(2, 13, 'hf, 32'hFFFFFFFF, 1, 13, 0, 32'h0);
    tbl[11] = mk(1, 15, 0, 32'h0, 2, 4, 'hf, 32'h0F0F0F0F);
    tbl[12] = mk(2, 5, 'h0, 32'hFFFFFFFF, 1, 4, 0, 32'h0F0F0F0F);
    tbl[13] = mk(1, 5, 0, 32'hDE22BE44, 2, 9, 'h3, 32'h87654321);
    tbl[14] = mk(1, 9, 0, 32'h12344321, 1, 9, 0, 32'h12344321);
    tbl[15] = mk(2, 11, 'hf, 32'hCAFE0001, 2, 11, 'hf, 32'hBEEF0002);
    tbl[16] = mk(1, 11, 0, 32'hCAFE0001, 1, 11, 0, 32'hCAFE0001);
    tbl[17] = mk(1, 9, 0, 32'h12344321, 2, 9, 'hf, 32'h0);

    rst_n = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_strobe = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_strobe = '0; b_wdata = '0;
    dir_a_en = 1'b0; dir_b_en = 1'b0; dir_a_val = '0; dir_b_val = '0;
    m_ready = 1'b0; exp_coll = 1'b0; clr_left = MS; cyc = 0;
    last_a = '0; last_b = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    count_clear("initial_clear_cycles");

    // Fill with garbage, then reset: the clear must wipe it all.
    for (int i = 0; i < MS; i++) begin
      drive_a(2, i, 'hf, $urandom());
      drive_b(0, 0, 0, 32'h0);
      tick();
    end
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_clear("reclear_cycles");
    for (int i = 0; i < MS; i++) begin
      drive_a(1, i, 0, 32'h0);
      drive_b(1, MS - 1 - i, 0, 32'h0);
      tick();
    end
    idle();
    repeat (RL + 1) tick();

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      drive_a(tbl[i].aop, tbl[i].aaddr, tbl[i].astrb, tbl[i].adata);
      drive_b(tbl[i].bop, tbl[i].baddr, tbl[i].bstrb, tbl[i].bdata);
      tick();
    end
    idle();
    repeat (RL + 1) tick();

    // Reset with a read in flight, then reset again part-way into the clear.
    drive_a(2, 0, 'hf, 32'h5A5A5A5A);
    drive_b(2, MS - 1, 'hf, 32'hA5A5A5A5);
    tick();
    drive_a(1, 0, 0, 32'h5A5A5A5A);
    drive_b(0, 0, 0, 32'h0);
    dir_a_en = 1'b0;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("inflight_data_cleared", a_rdata, 0);
    chk("inflight_valid_dropped", a_dv, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_clear("restart_clear_cycles");
    drive_a(1, 0, 0, 32'h0);
    drive_b(1, MS - 1, 0, 32'h0);
    tick();
    idle();
    repeat (RL + 1) tick();

    // Randomised traffic against the model.
    repeat (400) begin
      drive_random();
      tick();
    end
    idle();
    repeat (RL + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
